// File: rtl/ctrl_fifo_ram.sv
// Pointer/flag controller for the dual-port RAM behind a FIFO: turns push/pop into RAM
// strobes and addresses, and keeps binary/Gray pointers, fill count and status flags.
module ctrl_fifo_ram #(
  parameter int ADDR_WIDTH      = 4,
  parameter int UMBRAL_ALTO_DEF = 14,
  parameter int UMBRAL_BAJO_DEF = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_init,
  input  logic [ADDR_WIDTH:0]   i_umbral_alto,
  input  logic [ADDR_WIDTH:0]   i_umbral_bajo,
  input  logic                  i_push,
  input  logic                  i_pop,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH:0]   o_wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_error,
  output logic                  o_active
);

  // state  | meaning
  // IDLE   | after reset, waiting for the first init
  // INIT   | flushing pointers/count/error, thresholds loadable
  // ACTIVE | servicing push/pop requests
  typedef enum logic [1:0] {IDLE, INIT, ACTIVE} state_t;

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] ONE_L   = PW'(1);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_gray;
  logic [PW-1:0]  r_rd_gray;
  logic [PW-1:0]  r_count;
  logic [PW-1:0]  r_umbral_alto;
  logic [PW-1:0]  r_umbral_bajo;
  logic           r_error;

  logic           w_active;
  logic           w_full;
  logic           w_empty;
  logic           w_wr_en;
  logic           w_rd_en;
  logic           w_req_err;
  logic [PW-1:0]  w_wr_ptr_nxt;
  logic [PW-1:0]  w_rd_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_init)  w_state_nxt = INIT;
      INIT:    if (!i_init) w_state_nxt = ACTIVE;
      ACTIVE:  if (i_init)  w_state_nxt = INIT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flags come from the registered count only, so a simultaneous pop never frees a slot for push.
  assign w_active     = (r_state == ACTIVE);
  assign w_full       = (r_count == DEPTH_L);
  assign w_empty      = (r_count == '0);
  assign w_wr_en      = w_active & i_push & ~w_full;
  assign w_rd_en      = w_active & i_pop & ~w_empty;
  assign w_req_err    = w_active & ((i_push & w_full) | (i_pop & w_empty));
  assign w_wr_ptr_nxt = r_wr_ptr + ONE_L;
  assign w_rd_ptr_nxt = r_rd_ptr + ONE_L;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_wr_gray     <= '0;
      r_rd_gray     <= '0;
      r_count       <= '0;
      r_error       <= 1'b0;
      r_umbral_alto <= PW'(UMBRAL_ALTO_DEF);
      r_umbral_bajo <= PW'(UMBRAL_BAJO_DEF);
    end else begin
      // Thresholds follow the inputs while init is held, so the last value seen with init=1 sticks.
      if (i_init) begin
        r_umbral_alto <= i_umbral_alto;
        r_umbral_bajo <= i_umbral_bajo;
      end
      if (r_state == INIT) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_wr_gray <= '0;
        r_rd_gray <= '0;
        r_count   <= '0;
        r_error   <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr  <= w_wr_ptr_nxt;
          r_wr_gray <= bin2gray(w_wr_ptr_nxt);
        end
        if (w_rd_en) begin
          r_rd_ptr  <= w_rd_ptr_nxt;
          r_rd_gray <= bin2gray(w_rd_ptr_nxt);
        end
        case ({w_wr_en, w_rd_en})
          2'b10:   r_count <= r_count + ONE_L;
          2'b01:   r_count <= r_count - ONE_L;
          default: r_count <= r_count;
        endcase
        if (w_req_err) r_error <= 1'b1;
      end
    end
  end

  assign o_wr_en        = w_wr_en;
  assign o_rd_en        = w_rd_en;
  assign o_wr_addr      = r_wr_ptr[ADDR_WIDTH-1:0];
  assign o_rd_addr      = r_rd_ptr[ADDR_WIDTH-1:0];
  assign o_wr_ptr_gray  = r_wr_gray;
  assign o_rd_ptr_gray  = r_rd_gray;
  assign o_count        = r_count;
  assign o_fifo_full    = w_full;
  assign o_fifo_empty   = w_empty;
  assign o_almost_full  = (r_count >= r_umbral_alto);
  assign o_almost_empty = (r_count <= r_umbral_bajo);
  assign o_error        = r_error;
  assign o_active       = w_active;

endmodule

// File: tb/tb_ctrl_fifo_ram.sv
// Bench for ctrl_fifo_ram: directed and random push/pop/init/reset sequences checked every
// cycle against an occupancy/pointer-index model of the FIFO.
module tb_ctrl_fifo_ram;

  logic       clk = 1'b0;
  logic       i_reset, i_init, i_push, i_pop;
  logic [4:0] i_umbral_alto, i_umbral_bajo;
  logic       o_wr_en, o_rd_en, o_fifo_full, o_fifo_empty;
  logic       o_almost_full, o_almost_empty, o_error, o_active;
  logic [3:0] o_wr_addr, o_rd_addr;
  logic [4:0] o_wr_ptr_gray, o_rd_ptr_gray, o_count;

  always #5 clk = ~clk;

  ctrl_fifo_ram dut (
    .i_clk(clk), .i_reset(i_reset), .i_init(i_init),
    .i_umbral_alto(i_umbral_alto), .i_umbral_bajo(i_umbral_bajo),
    .i_push(i_push), .i_pop(i_pop),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_wr_ptr_gray(o_wr_ptr_gray), .o_rd_ptr_gray(o_rd_ptr_gray), .o_count(o_count),
    .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty),
    .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .o_error(o_error), .o_active(o_active)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0=idle 1=init 2=active; write/read indices modulo 32; occupancy count.
  int m_mode, m_wp, m_rp, m_cnt, m_err, m_alto, m_bajo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wp = 0; m_rp = 0; m_cnt = 0; m_err = 0; m_alto = 14; m_bajo = 2;
  endtask

  task automatic check_all();
    int we, re;
    we = (m_mode == 2 && i_push && m_cnt < 16) ? 1 : 0;
    re = (m_mode == 2 && i_pop && m_cnt > 0) ? 1 : 0;
    chk("wr_en", 32'(o_wr_en), 32'(we));
    chk("rd_en", 32'(o_rd_en), 32'(re));
    chk("wr_addr", 32'(o_wr_addr), 32'(m_wp % 16));
    chk("rd_addr", 32'(o_rd_addr), 32'(m_rp % 16));
    chk("wr_gray", 32'(o_wr_ptr_gray), 32'(gray(m_wp)));
    chk("rd_gray", 32'(o_rd_ptr_gray), 32'(gray(m_rp)));
    chk("count", 32'(o_count), 32'(m_cnt));
    chk("full", 32'(o_fifo_full), 32'(m_cnt == 16));
    chk("empty", 32'(o_fifo_empty), 32'(m_cnt == 0));
    chk("almost_full", 32'(o_almost_full), 32'(m_cnt >= m_alto));
    chk("almost_empty", 32'(o_almost_empty), 32'(m_cnt <= m_bajo));
    chk("error", 32'(o_error), 32'(m_err));
    chk("active", 32'(o_active), 32'(m_mode == 2));
  endtask

  task automatic model_edge(input bit rst, input bit ini, input bit ph, input bit pp);
    int we, re;
    if (rst) begin
      model_reset();
      return;
    end
    we = (m_mode == 2 && ph && m_cnt < 16) ? 1 : 0;
    re = (m_mode == 2 && pp && m_cnt > 0) ? 1 : 0;
    if (ini) begin
      m_alto = int'(i_umbral_alto);
      m_bajo = int'(i_umbral_bajo);
    end
    if (m_mode == 1) begin
      m_wp = 0; m_rp = 0; m_cnt = 0; m_err = 0;
    end else begin
      if (m_mode == 2 && ((ph && m_cnt == 16) || (pp && m_cnt == 0))) m_err = 1;
      m_wp = (m_wp + we) % 32;
      m_rp = (m_rp + re) % 32;
      m_cnt = m_cnt + we - re;
    end
    case (m_mode)
      0: if (ini) m_mode = 1;
      1: if (!ini) m_mode = 2;
      default: if (ini) m_mode = 1;
    endcase
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model on the rising edge.
  task automatic cyc(input bit rst, input bit ini, input bit ph, input bit pp, input bit do_chk);
    i_reset = rst; i_init = ini; i_push = ph; i_pop = pp;
    @(negedge clk);
    if (do_chk) check_all();
    @(posedge clk);
    model_edge(rst, ini, ph, pp);
    #1;
  endtask

  task automatic do_init(input logic [4:0] alto, input logic [4:0] bajo);
    i_umbral_alto = alto; i_umbral_bajo = bajo;
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  logic [4:0] prev_wg, prev_rg;

  initial begin
    model_reset();
    i_umbral_alto = 5'd14; i_umbral_bajo = 5'd2;
    // T1: reset with requests pending
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    chk("t1_idle_count", 32'(o_count), 32'd0);

    // T2: init then fill
    do_init(5'd12, 5'd3);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 0, 1);
    chk("t2_wr_gray", 32'(o_wr_ptr_gray), 32'b11000);
    chk("t2_full", 32'(o_fifo_full), 32'd1);

    // T3: push while full, then drain
    cyc(0, 0, 1, 0, 1);
    chk("t3_error", 32'(o_error), 32'd1);
    chk("t3_count", 32'(o_count), 32'd16);
    for (int k = 0; k < 16; k++) cyc(0, 0, 0, 1, 1);
    chk("t3_empty", 32'(o_fifo_empty), 32'd1);
    chk("t3_rd_gray", 32'(o_rd_ptr_gray), 32'b11000);

    // T4: simultaneous requests at full and at empty
    do_init(5'd12, 5'd3);
    chk("t4_err_cleared", 32'(o_error), 32'd0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    chk("t4_count15", 32'(o_count), 32'd15);
    chk("t4_error", 32'(o_error), 32'd1);
    for (int k = 0; k < 15; k++) cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    chk("t4_count1", 32'(o_count), 32'd1);

    // T5: steady push+pop at count 5, pointers wrap
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 1);
    for (int k = 0; k < 40; k++) begin
      prev_wg = o_wr_ptr_gray; prev_rg = o_rd_ptr_gray;
      cyc(0, 0, 1, 1, 1);
      chk("t5_wg_1bit", 32'($countones(prev_wg ^ o_wr_ptr_gray)), 32'd1);
      chk("t5_rg_1bit", 32'($countones(prev_rg ^ o_rd_ptr_gray)), 32'd1);
    end
    chk("t5_count", 32'(o_count), 32'd5);

    // random traffic
    for (int k = 0; k < 200; k++)
      cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);

    // T6: reset mid-operation, then re-init during ACTIVE with overlapping thresholds
    do_init(5'd14, 5'd2);
    for (int k = 0; k < 9; k++) cyc(0, 0, 1, 0, 1);
    chk("t6_count9", 32'(o_count), 32'd9);
    cyc(1, 0, 1, 1, 1);
    chk("t6_rst_count", 32'(o_count), 32'd0);
    chk("t6_rst_active", 32'(o_active), 32'd0);
    chk("t6_rst_error", 32'(o_error), 32'd0);
    do_init(5'd5, 5'd8);
    for (int k = 0; k < 100; k++)
      cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    do_init(5'($urandom_range(0, 16)), 5'($urandom_range(0, 16)));
    chk("t6_flushed", 32'(o_count), 32'd0);
    for (int k = 0; k < 100; k++)
      cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
